bht_predictor: RTL and testbench

Parametrised branch history table of saturating counters for the fetch-stage branch predictor. Separate predict and update ports, registered one-cycle prediction, and a self-initialising table swept by an init FSM after reset or flush. An optional gshare mode XORs a global history register into the index.

---
 rtl/bht_predictor_if.sv | 29 ++
 rtl/bht_predictor.sv | 140 ++++++++++++++
 tb/tb_bht_predictor.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bht_predictor_if.sv
// Request/response bundle between the fetch stage and the branch history table.
// master: fetch/resolve side driving requests; slave: the predictor itself.
interface bht_predictor_if #(
  parameter int CTR_W = 2,
  parameter int GHR_W = 10
);
  logic             flush;
  logic             ready;
  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic             pred_out_valid;
  logic             pred_taken;
  logic [CTR_W-1:0] pred_ctr;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [GHR_W-1:0] upd_ghr;

  modport master (
    output flush, pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_ghr,
    input  ready, pred_out_valid, pred_taken, pred_ctr, pred_ghr
  );

  modport slave (
    input  flush, pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_ghr,
    output ready, pred_out_valid, pred_taken, pred_ctr, pred_ghr
  );
endinterface

// File: rtl/bht_predictor.sv
// Branch history table of saturating counters with a registered one-cycle
// prediction and a self-initialising sweep after reset or flush.
// Optional macro GSHARE_EN: adds a non-speculative global history register
// XORed into the table index; otherwise a plain bimodal predictor.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweeping WEAK_NT into every entry, requests ignored
// ST_RUN  | table valid, predictions and updates accepted
module bht_predictor #(
  parameter int ENTRIES = 1024,
  parameter int CTR_W   = 2,
  parameter int PC_LSB  = 2,
  parameter int GHR_W   = 10
) (
  input logic clk,
  input logic rst,
  bht_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] WEAK_NT  = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_idx;
  logic             ready_q;
  logic             pred_out_valid_q;
  logic             pred_taken_q;
  logic [CTR_W-1:0] pred_ctr_q;

  logic [CTR_W-1:0] table_mem [ENTRIES];

  logic [IDX_W-1:0] pred_base, upd_base, pred_idx, upd_idx;
  logic             pred_en, upd_en;
  logic [CTR_W-1:0] upd_cur, upd_next, pred_raw, pred_fwd;
  logic             unused_ok;

  assign pred_base = bus.pred_pc[PC_LSB +: IDX_W];
  assign upd_base  = bus.upd_pc[PC_LSB +: IDX_W];

  // A flush cycle drops both the update and the prediction request.
  assign pred_en = (state == ST_RUN) && bus.pred_valid && !bus.flush;
  assign upd_en  = (state == ST_RUN) && bus.upd_valid && !bus.flush;

`ifdef GSHARE_EN
  logic [GHR_W-1:0] ghr, pred_ghr_q;
  logic [GHR_W:0]   ghr_shift;

  assign ghr_shift    = {ghr, bus.upd_taken};
  assign pred_idx     = pred_base ^ IDX_W'(ghr);
  assign upd_idx      = upd_base ^ IDX_W'(bus.upd_ghr);
  assign bus.pred_ghr = pred_ghr_q;
  assign unused_ok    = ^{bus.pred_pc, bus.upd_pc, ghr_shift[GHR_W]};

  // Global history follows resolved branches only; held clear while sweeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr        <= '0;
      pred_ghr_q <= '0;
    end else begin
      if (state == ST_INIT || bus.flush) ghr <= '0;
      else if (upd_en)                   ghr <= ghr_shift[GHR_W-1:0];
      if (pred_en) pred_ghr_q <= ghr;
    end
  end
`else
  assign pred_idx     = pred_base;
  assign upd_idx      = upd_base;
  assign bus.pred_ghr = '0;
  assign unused_ok    = ^{bus.pred_pc, bus.upd_pc, bus.upd_ghr};
`endif

  assign upd_cur  = table_mem[upd_idx];
  assign pred_raw = table_mem[pred_idx];
  // A same-cycle update to the predicted entry is forwarded to the prediction.
  assign pred_fwd = (upd_en && (upd_idx == pred_idx)) ? upd_next : pred_raw;

  // Saturating step of the counter being updated.
  always_comb begin
    upd_next = upd_cur;
    if (bus.upd_taken) begin
      if (upd_cur != CTR_MAX) upd_next = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_next = upd_cur - 1'b1;
    end
  end

  // Table write port: init sweep has priority, otherwise resolved updates.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) table_mem[init_idx] <= WEAK_NT;
    else if (upd_en)      table_mem[upd_idx]  <= upd_next;
  end

  // Sequencer plus registered prediction outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_INIT;
      init_idx         <= '0;
      ready_q          <= 1'b0;
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_ctr_q       <= '0;
    end else begin
      pred_out_valid_q <= pred_en;
      if (pred_en) begin
        pred_ctr_q   <= pred_fwd;
        pred_taken_q <= pred_fwd[CTR_W-1];
      end
      case (state)
        ST_INIT: begin
          if (bus.flush) begin
            init_idx <= '0;
          end else if (init_idx == LAST_IDX) begin
            state    <= ST_RUN;
            ready_q  <= 1'b1;
            init_idx <= '0;
          end else begin
            init_idx <= init_idx + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.flush) begin
            state    <= ST_INIT;
            ready_q  <= 1'b0;
            init_idx <= '0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.ready          = ready_q;
  assign bus.pred_out_valid = pred_out_valid_q;
  assign bus.pred_taken     = pred_taken_q;
  assign bus.pred_ctr       = pred_ctr_q;
endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: 16 entries, 2-bit counters, PC_LSB=2.
module tb_bht_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n;
  logic pov_seen;

  bht_predictor_if #(.CTR_W(2), .GHR_W(4)) bus ();

  bht_predictor #(.ENTRIES(16), .CTR_W(2), .PC_LSB(2), .GHR_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus, then all request strobes dropped.
  task automatic drive(input logic pv, input logic [31:0] ppc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [3:0] ug);
    bus.pred_valid = pv;
    bus.pred_pc    = ppc;
    bus.upd_valid  = uv;
    bus.upd_pc     = upc;
    bus.upd_taken  = ut;
    bus.upd_ghr    = ug;
    tick();
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
  endtask

  task automatic predict(input logic [31:0] pc);
    drive(1'b1, pc, 1'b0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic update(input logic [31:0] pc, input logic tk);
    drive(1'b0, 32'h0, 1'b1, pc, tk, 4'h0);
  endtask

  // Counts edges until ready rises; 0 if it never does within the bound.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.pred_out_valid) pov_seen = 1'b1;
      if (bus.ready) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.pred_valid = 1'b0; bus.pred_pc = 32'h0;
    bus.upd_valid = 1'b0;  bus.upd_pc = 32'h0;
    bus.upd_taken = 1'b0;  bus.upd_ghr = 4'h0;
    pov_seen = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", bus.ready, 0);
    chk("rst_pov", bus.pred_out_valid, 0);
    chk("rst_ctr", bus.pred_ctr, 0);
    chk("rst_taken", bus.pred_taken, 0);
    chk("rst_ghr", bus.pred_ghr, 0);

    // Init sweep with requests held active; all must be ignored
    bus.pred_valid = 1'b1; bus.pred_pc = 32'h40;
    bus.upd_valid = 1'b1;  bus.upd_pc = 32'h40; bus.upd_taken = 1'b1;
    rst = 1'b0;
    wait_ready(n);
    bus.pred_valid = 1'b0; bus.upd_valid = 1'b0;
    chk("init_cycles", n, 16);
    chk("init_no_pov", pov_seen, 0);

    predict(32'h40);
    chk("init_pov", bus.pred_out_valid, 1);
    chk("init_ctr", bus.pred_ctr, 1);
    chk("init_taken", bus.pred_taken, 0);
    tick();
    chk("idle_pov", bus.pred_out_valid, 0);
    chk("idle_hold_ctr", bus.pred_ctr, 1);

`ifdef GSHARE_EN
    // History T,T -> 0011; predict 0x40 indexes 0^3
    update(32'h40, 1'b1);
    update(32'h40, 1'b1);
    predict(32'h40);
    chk("gs_ghr_011", bus.pred_ghr, 3);
    chk("gs_ctr_e3", bus.pred_ctr, 1);
    // Then N -> 0110; entry 0 now holds 2, entry 6 holds 1
    update(32'h40, 1'b0);
    predict(32'h40);
    chk("gs_ghr_110", bus.pred_ghr, 6);
    chk("gs_ctr_e6", bus.pred_ctr, 1);
    predict(32'h58);
    chk("gs_ctr_e0", bus.pred_ctr, 2);
`else
    // Saturation up
    repeat (4) update(32'h40, 1'b1);
    predict(32'h40);
    chk("sat_up_ctr", bus.pred_ctr, 3);
    chk("sat_up_taken", bus.pred_taken, 1);
    update(32'h40, 1'b1);
    predict(32'h40);
    chk("sat_up_hold", bus.pred_ctr, 3);
    // Saturation down
    repeat (4) update(32'h40, 1'b0);
    predict(32'h40);
    chk("sat_dn_ctr", bus.pred_ctr, 0);
    chk("sat_dn_taken", bus.pred_taken, 0);
    update(32'h40, 1'b0);
    predict(32'h40);
    chk("sat_dn_hold", bus.pred_ctr, 0);

    // Forwarding: entry 0 at 01, same-cycle taken update + predict
    update(32'h40, 1'b1);
    drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 4'h0);
    chk("fwd_same_ctr", bus.pred_ctr, 2);
    chk("fwd_same_taken", bus.pred_taken, 1);
    drive(1'b1, 32'h44, 1'b1, 32'h40, 1'b1, 4'h0);
    chk("fwd_other_ctr", bus.pred_ctr, 1);

    // Back-to-back not-taken updates: 3 -> 0
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h40; bus.upd_taken = 1'b0;
    repeat (3) tick();
    bus.upd_valid = 1'b0;
    predict(32'h40);
    chk("b2b_ctr", bus.pred_ctr, 0);

    // Aliasing: 0x80 shares entry 0 with 0x40
    update(32'h80, 1'b1);
    predict(32'h40);
    chk("alias_1", bus.pred_ctr, 1);
    update(32'h80, 1'b1);
    update(32'h80, 1'b1);
    predict(32'h40);
    chk("alias_3", bus.pred_ctr, 3);

    // Flush mid-RUN with requests in the same cycle
    bus.flush = 1'b1;
    drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 4'h0);
    bus.flush = 1'b0;
    chk("flush_ready", bus.ready, 0);
    chk("flush_pov", bus.pred_out_valid, 0);
    pov_seen = 1'b0;
    wait_ready(n);
    chk("flush_cycles", n, 16);
    chk("flush_no_pov", pov_seen, 0);
    predict(32'h40);
    chk("flush_reinit", bus.pred_ctr, 1);

    // Bimodal: history has no effect on indexing
    update(32'h40, 1'b1);
    update(32'h40, 1'b1);
    update(32'h40, 1'b0);
    predict(32'h40);
    chk("bim_ctr", bus.pred_ctr, 2);
    chk("bim_ghr", bus.pred_ghr, 0);
`endif

    // Async reset mid-INIT at init_idx=7
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (7) tick();
    chk("mid_init_ready", bus.ready, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_ready", bus.ready, 0);
    chk("arst_pov", bus.pred_out_valid, 0);
    chk("arst_ctr", bus.pred_ctr, 0);
    chk("arst_taken", bus.pred_taken, 0);
    chk("arst_ghr", bus.pred_ghr, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_ready(n);
    chk("arst_init_cycles", n, 16);
    predict(32'h40);
    chk("arst_reinit", bus.pred_ctr, 1);
    chk("arst_reinit_pov", bus.pred_out_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
